// File: rtl/hourglass_ctrl.sv
// e-hourglass control stage: key debounce, IDLE/RUN/DONE sequencing,
// speed selection and grain-fall tick generation for the LCD driver.
module key_deb #(
  parameter int DEB_CYC = 20
) (
  input  logic clk_LCD,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= key;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_q;

endmodule

module hourglass_ctrl #(
  parameter int DEB_CYC = 20,
  parameter int GRAINS  = 32
) (
  input  logic       clk_LCD,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_up,
  input  logic       key_down,
  output logic       stop,
  output logic [1:0] speed,
  output logic       fall_tick,
  output logic [5:0] top_cnt,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } st_t;

  localparam logic [5:0] G6 = 6'(GRAINS);

  st_t        st;
  st_t        st_nxt;
  logic       p_start;
  logic       p_up;
  logic       p_down;
  logic [1:0] spd_nxt;
  logic [9:0] tcnt;
  logic [9:0] tcnt_nxt;
  logic [9:0] period;
  logic       at_end;
  logic [5:0] top_nxt;
  logic       tick_nxt;
  logic       stop_nxt;
  logic       done_nxt;

  key_deb #(.DEB_CYC(DEB_CYC)) u_deb_start (
    .clk_LCD (clk_LCD),
    .rst_n   (rst_n),
    .key     (key_start),
    .press   (p_start)
  );

  key_deb #(.DEB_CYC(DEB_CYC)) u_deb_up (
    .clk_LCD (clk_LCD),
    .rst_n   (rst_n),
    .key     (key_up),
    .press   (p_up)
  );

  key_deb #(.DEB_CYC(DEB_CYC)) u_deb_down (
    .clk_LCD (clk_LCD),
    .rst_n   (rst_n),
    .key     (key_down),
    .press   (p_down)
  );

  assign period = 10'd1000 >> speed;
  assign at_end = (tcnt == period - 10'd1);

  always_comb begin
    spd_nxt = speed;
    if (p_up && !p_down && speed != 2'd3) begin
      spd_nxt = speed + 2'd1;
    end else if (p_down && !p_up && speed != 2'd0) begin
      spd_nxt = speed - 2'd1;
    end
  end

  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Abort has priority over a tick landing on the same edge.
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE: if (p_start) st_nxt = RUN;
      RUN: begin
        if (p_start) begin
          st_nxt = IDLE;
        end else if (at_end && top_cnt == 6'd1) begin
          st_nxt = DONE;
        end
      end
      DONE: if (p_start) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    tcnt_nxt = '0;
    top_nxt  = top_cnt;
    tick_nxt = 1'b0;
    stop_nxt = (st_nxt != RUN);
    done_nxt = (st_nxt == DONE);
    unique case (st)
      IDLE: top_nxt = G6;
      RUN: begin
        if (p_start) begin
          top_nxt = G6;
        end else if (at_end) begin
          tick_nxt = 1'b1;
          top_nxt  = top_cnt - 6'd1;
        end else if (spd_nxt == speed) begin
          tcnt_nxt = tcnt + 10'd1;
        end
      end
      DONE: top_nxt = p_start ? G6 : 6'd0;
      default: top_nxt = G6;
    endcase
  end

  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) begin
      stop      <= 1'b1;
      speed     <= 2'd0;
      fall_tick <= 1'b0;
      top_cnt   <= G6;
      done      <= 1'b0;
      tcnt      <= '0;
    end else begin
      stop      <= stop_nxt;
      speed     <= spd_nxt;
      fall_tick <= tick_nxt;
      top_cnt   <= top_nxt;
      done      <= done_nxt;
      tcnt      <= tcnt_nxt;
    end
  end

endmodule

// File: tb/tb_hourglass_ctrl.sv
// Self-checking bench for hourglass_ctrl: key timing, speed saturation,
// tick schedule, abort, done and reset behaviour against a reference model.
module tb_hourglass_ctrl;

  localparam int DEB = 20;
  localparam int G   = 4;
  localparam int LAT = DEB + 3;

  logic       clk_LCD = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_start = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic       stop;
  logic [1:0] speed;
  logic       fall_tick;
  logic [5:0] top_cnt;
  logic       done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tq[$];
  int tc[$];
  int m_speed = 0;

  hourglass_ctrl #(.DEB_CYC(DEB), .GRAINS(G)) dut (
    .clk_LCD   (clk_LCD),
    .rst_n     (rst_n),
    .key_start (key_start),
    .key_up    (key_up),
    .key_down  (key_down),
    .stop      (stop),
    .speed     (speed),
    .fall_tick (fall_tick),
    .top_cnt   (top_cnt),
    .done      (done)
  );

  always #5 clk_LCD = ~clk_LCD;

  always @(posedge clk_LCD) cyc <= cyc + 1;

  always @(negedge clk_LCD) begin
    if (fall_tick === 1'b1) begin
      tq.push_back(cyc);
      tc.push_back(int'(top_cnt));
    end
  end

  function automatic int period(input int s);
    return 1000 / (1 << s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_LCD);
  endtask

  // k: 0 start, 1 up, 2 down, 3 up+down; eff = edge where effect lands
  task automatic press(input int k, output int eff);
    @(negedge clk_LCD);
    eff = cyc + LAT;
    key_start = (k == 0);
    key_up    = (k == 1 || k == 3);
    key_down  = (k == 2 || k == 3);
    repeat ($urandom_range(DEB + 15, DEB + 4)) @(negedge clk_LCD);
    key_start = 1'b0;
    key_up    = 1'b0;
    key_down  = 1'b0;
    repeat ($urandom_range(DEB + 15, DEB + 5)) @(negedge clk_LCD);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stop"}, stop, 1);
    chk({tag, "_speed"}, speed, 0);
    chk({tag, "_tick"}, fall_tick, 0);
    chk({tag, "_top"}, top_cnt, G);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int e0;
    int eu;
    int ea;
    int c;
    int off;

    #1 rst_n = 1'b0;
    #1 chk_reset("rst");
    repeat (3) @(negedge clk_LCD);
    rst_n = 1'b1;
    repeat (2000) begin
      @(negedge clk_LCD);
      chk("idle_hold", {stop, speed, fall_tick, top_cnt, done},
          {1'b1, 2'd0, 1'b0, 6'(G), 1'b0});
    end

    // glitch shorter than the debounce window
    @(negedge clk_LCD);
    key_up = 1'b1;
    repeat ($urandom_range(DEB - 5, 5)) @(negedge clk_LCD);
    key_up = 1'b0;
    repeat (40) @(negedge clk_LCD);
    chk("glitch_speed", speed, m_speed);

    // exact key latency
    @(negedge clk_LCD);
    c = cyc;
    key_up = 1'b1;
    repeat (LAT - 1) @(negedge clk_LCD);
    chk("lat_before", speed, 0);
    @(negedge clk_LCD);
    m_speed = 1;
    chk("lat_after", speed, m_speed);
    chk("lat_cycles", cyc - c, LAT);
    repeat (30 - LAT) @(negedge clk_LCD);
    key_up = 1'b0;
    repeat (30) @(negedge clk_LCD);

    for (int i = 0; i < 5; i++) begin
      press(1, e0);
      m_speed = (m_speed < 3) ? m_speed + 1 : 3;
      chk("sat_up", speed, m_speed);
    end
    for (int i = 0; i < 5; i++) begin
      press(2, e0);
      m_speed = (m_speed > 0) ? m_speed - 1 : 0;
      chk("sat_down", speed, m_speed);
    end
    press(1, e0);
    m_speed = 1;
    press(3, e0);
    chk("up_down_same", speed, m_speed);

    // full run at speed 3
    press(1, e0);
    press(1, e0);
    m_speed = 3;
    chk("run_speed", speed, m_speed);
    tq.delete();
    tc.delete();
    press(0, e0);
    chk("run_stop", stop, 0);
    chk("run_top0", top_cnt, G);
    wait_until(e0 + G * period(m_speed) + 3);
    chk("run_ticks", tq.size(), G);
    for (int i = 0; i < G; i++) begin
      chk("run_tick_t", (i < tq.size()) ? tq[i] - e0 : -1,
          (i + 1) * period(m_speed));
      chk("run_tick_top", (i < tc.size()) ? tc[i] : -1, G - 1 - i);
    end
    chk("done_done", done, 1);
    chk("done_stop", stop, 1);
    chk("done_top", top_cnt, 0);
    press(0, e0);
    chk("rearm_stop", stop, 1);
    chk("rearm_done", done, 0);
    chk("rearm_top", top_cnt, G);

    // speed change then abort in RUN
    for (int i = 0; i < 3; i++) press(2, e0);
    m_speed = 0;
    chk("slow_speed", speed, m_speed);
    tq.delete();
    tc.delete();
    press(0, e0);
    off = $urandom_range(650, 550);
    wait_until(e0 + off);
    eu = cyc + LAT;
    key_up = 1'b1;
    repeat (DEB + 8) @(negedge clk_LCD);
    key_up = 1'b0;
    m_speed = 1;
    wait_until(eu + period(m_speed) + 5);
    chk("chg_speed", speed, m_speed);
    chk("chg_ticks", tq.size(), 1);
    chk("chg_tick_t", (tq.size() > 0) ? tq[0] - eu : -1, period(m_speed));
    chk("chg_tick_top", (tc.size() > 0) ? tc[0] : -1, G - 1);
    press(0, ea);
    repeat (1200) @(negedge clk_LCD);
    chk("abort_stop", stop, 1);
    chk("abort_top", top_cnt, G);
    chk("abort_done", done, 0);
    chk("abort_ticks", tq.size(), 1);

    // reset in the middle of a run
    tq.delete();
    press(0, e0);
    wait_until(e0 + 300);
    chk("mid_stop", stop, 0);
    rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    m_speed = 0;
    repeat (3) @(negedge clk_LCD);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk_LCD);
    chk("post_rst_ticks", tq.size(), 0);
    chk("post_rst_stop", stop, 1);
    chk("post_rst_speed", speed, m_speed);
    chk("post_rst_top", top_cnt, G);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hourglass_ctrl.md
# hourglass_ctrl

Control stage for the e-hourglass, directly upstream of the LCD driver. Debounces the three front-panel keys, runs the IDLE/RUN/DONE sequence that drives the LCD's `stop` input, and maintains the 2-bit `speed` shown on the LCD. In RUN it generates the grain-fall tick at a speed-dependent period and counts grains remaining in the top bulb. It runs on the same 1 kHz `clk_LCD` as the LCD driver, so its outputs connect to the driver with no clock-domain crossing.

## Interface
- DEB_CYC, 20, number of consecutive stable cycles (ms) required to accept a key level change
- GRAINS, 32, grains loaded into the top bulb at start; range 1..63

- clk_LCD  in  1  1 kHz system clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_start  in  1  raw start/abort key, active high, asynchronous
- key_up  in  1  raw speed-up key, active high, asynchronous
- key_down  in  1  raw speed-down key, active high, asynchronous
- stop  out  1  1 = welcome/idle screen; 0 = hourglass running
- speed  out  2  current speed, 0 (slowest) to 3 (fastest)
- fall_tick  out  1  one-cycle pulse, one grain falls
- top_cnt  out  6  grains remaining in the top bulb
- done  out  1  high while the hourglass is empty

## Operation
- Reset values (rst_n low, applied asynchronously):
  - `stop` = 1, `speed` = 0, `fall_tick` = 0, `top_cnt` = GRAINS, `done` = 0
  - state = IDLE
  - all debounce registers and counters = 0
- Debounce, one identical instance per key:
  - The raw key passes through a 2-flop synchroniser (s1 → s2).
  - A counter increments each cycle while s2 ≠ the debounced level `db`, and clears to 0 whenever s2 = `db`.
  - At an edge where the counter = DEB_CYC−1 and s2 ≠ `db`: `db` takes the value of s2 and the counter clears.
  - press = `db` & ~`db_q`, where `db_q` is `db` delayed one cycle. press is high for exactly one cycle per accepted press.
  - Releases produce no event.
- Speed control:
  - up press: `speed` increments and saturates at 3.
  - down press: `speed` decrements and saturates at 0.
  - up and down press in the same cycle: no change.
  - Speed is adjustable in every state.
- State machine:
  - IDLE:
    - Outputs: `stop` = 1, `done` = 0, `top_cnt` held at GRAINS.
    - start press: go to RUN and clear the tick counter.
  - RUN:
    - Outputs: `stop` = 0.
    - Tick counter (10 bits) counts 0 .. P−1, where P = 1000 >> `speed` (1000, 500, 250, 125 cycles).
    - At the edge where the counter = P−1: counter clears, `fall_tick` is set for one cycle, and `top_cnt` decrements by 1.
    - If that decrement takes `top_cnt` from 1 to 0, go to DONE on the same edge.
    - start press: abort to IDLE; `top_cnt` reloads GRAINS and no tick is issued on that edge.
    - Any accepted speed change in RUN clears the tick counter on the same edge.
  - DONE:
    - Outputs: `stop` = 1, `done` = 1, `top_cnt` = 0.
    - start press: go to IDLE with `top_cnt` = GRAINS and `done` = 0.
- Simultaneous events in RUN: if a start press coincides with the counter reaching P−1, the abort wins. No tick is issued and `top_cnt` reloads.
- `fall_tick` is never asserted outside RUN.

## Timing
- Key latency: the raw level is first sampled by s1 at edge 1. `db` changes at edge DEB_CYC+2. The press pulse is high during the following cycle, and its effect (state, `speed`) becomes visible after edge DEB_CYC+3. With the default, that is 23 cycles (23 ms).
- A glitch shorter than DEB_CYC cycles at s2 produces no press.
- First `fall_tick` after entering RUN: asserted in the cycle following the P-th edge after the transition edge.
- Tick cadence: subsequent ticks are exactly P cycles apart while `speed` is constant.
- All outputs are registered; there is no combinational path from input to output.
- Reset assertion mid-RUN: outputs immediately take their reset values, with no partial tick.

## Test plan
- **Reset and idle:** hold rst_n = 0, then release. Required: `stop` = 1, `speed` = 0, `top_cnt` = 32, `fall_tick` = 0, `done` = 0; no change over 2000 idle cycles.
- **Debounce:**
  - Pulse key_up for 10 cycles, then release. Required: `speed` stays 0.
  - Hold key_up for 30 cycles. Required: `speed` = 1, with the change visible exactly 23 cycles after the edge that first samples it.
- **Saturation:**
  - Apply 5 clean up-presses. Required: `speed` = 3.
  - Then apply 5 down-presses. Required: `speed` = 0.
  - Simultaneous up and down press. Required: unchanged.
- **Full run (GRAINS = 4, speed = 3):**
  - Start. Required: `stop` = 0; `fall_tick` at cycles 125, 250, 375 and 500 after entering RUN; `top_cnt` 3, 2, 1, 0.
  - After the 4th tick: `done` = 1 and `stop` = 1.
  - Another start press. Required: IDLE with `top_cnt` = 4 and `done` = 0.
- **Speed change and abort in RUN:**
  - At speed 0, 600 cycles into RUN, press up. Required: next tick 500 cycles after the accepted press.
  - Then press start. Required: `stop` = 1, `top_cnt` = GRAINS, no further ticks.
- **Reset mid-run:** pull rst_n low 300 cycles into RUN. Required: all outputs return to reset values immediately, and no `fall_tick` is issued after release.
